f5_truth_checker: RTL and testbench

- Sequential stimulus-and-check end of the f5 interface: drives every input minterm onto a pair of f5 implementations (gate form and expression form), samples both outputs, and compares them to a parameterised truth table.
- Replaces the free-running initial-block bench with synthesizable hardware.
- Sits opposite the f5 modules: its stim outputs feed their inputs, and their outputs return on resp_a and resp_b.

---
 rtl/f5_truth_checker_if.sv | 33 +++
 rtl/f5_truth_checker.sv | 123 ++++++++++++
 tb/tb_f5_truth_checker.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/f5_truth_checker_if.sv
// f5 checker bus: start request, responses from the two f5 forms, stimulus and results.
`default_nettype none

interface f5_truth_checker_if #(
  parameter int N = 2
);
  logic         start;
  logic         resp_a;
  logic         resp_b;
  logic [N-1:0] stim;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic [N-1:0] first_err_m;
  logic         first_err_valid;
  logic         err_a_seen;
  logic         err_b_seen;

  modport master (
    input  start, resp_a, resp_b,
    output stim, busy, done, pass, err_count, first_err_m,
           first_err_valid, err_a_seen, err_b_seen
  );

  modport slave (
    output start, resp_a, resp_b,
    input  stim, busy, done, pass, err_count, first_err_m,
           first_err_valid, err_a_seen, err_b_seen
  );
endinterface

`default_nettype wire

// File: rtl/f5_truth_checker.sv
// f5_truth_checker: sweeps every minterm onto two f5 forms and scores both against TRUTH.
`default_nettype none

module f5_truth_checker #(
  parameter int               N      = 2,
  parameter logic [2**N-1:0]  TRUTH  = 4'b0010,
  parameter int               SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  f5_truth_checker_if.master   bus
);

  localparam int             CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [N-1:0]   STIM_LAST   = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   stim;
  logic           busy;
  logic           done;
  logic           pass;
  logic [N:0]     err_count;
  logic [N-1:0]   first_err_m;
  logic           first_err_valid;
  logic           err_a_seen;
  logic           err_b_seen;

  logic           exp_bit;
  logic           ma;
  logic           mb;
  logic           any_err;

  assign exp_bit = TRUTH[stim];
  assign ma      = (bus.resp_a != exp_bit);
  assign mb      = (bus.resp_b != exp_bit);
  assign any_err = ma | mb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      stim            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_m     <= '0;
      first_err_valid <= 1'b0;
      err_a_seen      <= 1'b0;
      err_b_seen      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // A new sweep clears the previous results on the same edge that accepts start.
          if (bus.start) begin
            state           <= S_SETTLE;
            cnt             <= '0;
            stim            <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_m     <= '0;
            first_err_valid <= 1'b0;
            err_a_seen      <= 1'b0;
            err_b_seen      <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (any_err) begin
            err_count <= err_count + (N+1)'(1);
            if (!first_err_valid) begin
              first_err_m     <= stim;
              first_err_valid <= 1'b1;
            end
          end
          err_a_seen <= err_a_seen | ma;
          err_b_seen <= err_b_seen | mb;
          if (stim == STIM_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !any_err && (err_count == '0);
          end else begin
            state <= S_SETTLE;
            stim  <= stim + 1'b1;
            cnt   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stim            = stim;
  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.pass            = pass;
  assign bus.err_count       = err_count;
  assign bus.first_err_m     = first_err_m;
  assign bus.first_err_valid = first_err_valid;
  assign bus.err_a_seen      = err_a_seen;
  assign bus.err_b_seen      = err_b_seen;

endmodule

`default_nettype wire

// File: tb/tb_f5_truth_checker.sv
// Directed bench for f5_truth_checker: modelled f5 responses with injectable faults.
`default_nettype none

module tb_f5_truth_checker;

  logic clk;
  logic rst_n;
  int   mode_a;
  int   mode_b;
  int   n_cmp;
  int   n_bad;

  f5_truth_checker_if #(.N(2)) bus1 ();
  f5_truth_checker_if #(.N(2)) bus2 ();

  f5_truth_checker #(.N(2), .TRUTH(4'b0010), .SETTLE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  f5_truth_checker #(.N(2), .TRUTH(4'b0010), .SETTLE(3)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0 correct a'.b, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
  function automatic logic f5_model(input int mode, input logic [1:0] s);
    logic good;
    good = (s == 2'd1);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~good;
      default: return good;
    endcase
  endfunction

  always_comb begin
    bus1.resp_a = f5_model(mode_a, bus1.stim);
    bus1.resp_b = f5_model(mode_b, bus1.stim);
    bus2.resp_a = f5_model(mode_a, bus2.stim);
    bus2.resp_b = f5_model(mode_b, bus2.stim);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 1) bus1.start = v;
    else            bus2.start = v;
  endtask

  function automatic logic get_done(input int which);
    return (which == 1) ? bus1.done : bus2.done;
  endfunction

  function automatic logic get_busy(input int which);
    return (which == 1) ? bus1.busy : bus2.busy;
  endfunction

  // Pulses start, optionally re-pulses it at cycles 2 and 5, then checks done lands at cycle lat.
  task automatic run_sweep(input int which, input int lat, input bit repulse, input bit chk_stim);
    @(negedge clk) set_start(which, 1'b1);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      set_start(which, repulse && (k == 1 || k == 4));
      chk("done_early", 32'(get_done(which)), 32'd0);
      chk("busy_run",   32'(get_busy(which)), 32'd1);
      if (chk_stim) chk("stim_seq", 32'(bus1.stim), 32'(k / 2));
    end
    @(negedge clk);
    set_start(which, 1'b0);
    chk("done_at_lat", 32'(get_done(which)), 32'd1);
    chk("busy_end",    32'(get_busy(which)), 32'd0);
  endtask

  task automatic chk_results(input string tag, input logic p, input int cnt, input logic [1:0] fm,
                             input logic fv, input logic ea, input logic eb);
    chk({tag, "_pass"},  32'(bus1.pass),            32'(p));
    chk({tag, "_cnt"},   32'(bus1.err_count),       32'(cnt));
    chk({tag, "_fm"},    32'(bus1.first_err_m),     32'(fm));
    chk({tag, "_fv"},    32'(bus1.first_err_valid), 32'(fv));
    chk({tag, "_ea"},    32'(bus1.err_a_seen),      32'(ea));
    chk({tag, "_eb"},    32'(bus1.err_b_seen),      32'(eb));
    chk({tag, "_stim"},  32'(bus1.stim),            32'd3);
  endtask

  function automatic logic [12:0] pack1();
    return {bus1.stim, bus1.busy, bus1.done, bus1.pass, bus1.err_count, bus1.first_err_m,
            bus1.first_err_valid, bus1.err_a_seen, bus1.err_b_seen};
  endfunction

  initial begin
    logic done_ever;
    n_cmp      = 0;
    n_bad      = 0;
    mode_a     = 0;
    mode_b     = 0;
    rst_n      = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_all", 32'(pack1()), 32'd0);
    rst_n = 1'b1;

    // Correct responses, stim sequence checked cycle by cycle.
    run_sweep(1, 8, 1'b0, 1'b1);
    chk_results("good", 1'b1, 0, 2'd0, 1'b0, 1'b0, 1'b0);

    // resp_a stuck at 0: only minterm 1 disagrees.
    mode_a = 1; mode_b = 0;
    run_sweep(1, 8, 1'b0, 1'b0);
    chk_results("a_sa0", 1'b0, 1, 2'd1, 1'b1, 1'b1, 1'b0);

    // resp_b inverted: all four minterms disagree.
    mode_a = 0; mode_b = 3;
    run_sweep(1, 8, 1'b0, 1'b0);
    chk_results("b_inv", 1'b0, 4, 2'd0, 1'b1, 1'b0, 1'b1);

    // Both stuck at 1: minterms 0, 2, 3 disagree, counted once each.
    mode_a = 2; mode_b = 2;
    run_sweep(1, 8, 1'b0, 1'b0);
    chk_results("both_sa1", 1'b0, 3, 2'd0, 1'b1, 1'b1, 1'b1);

    // Restart from a failing DONE with correct responses; results clear on the accepting edge.
    mode_a = 0; mode_b = 0;
    @(negedge clk) bus1.start = 1'b1;
    @(negedge clk) bus1.start = 1'b0;
    chk("restart_cnt",  32'(bus1.err_count),       32'd0);
    chk("restart_fv",   32'(bus1.first_err_valid), 32'd0);
    chk("restart_flag", 32'({bus1.err_a_seen, bus1.err_b_seen}), 32'd0);
    chk("restart_done", 32'(bus1.done),            32'd0);
    repeat (7) @(negedge clk);
    chk("restart_early", 32'(bus1.done), 32'd0);
    @(negedge clk);
    chk_results("restart", 1'b1, 0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Start re-pulsed mid-sweep is ignored.
    run_sweep(1, 8, 1'b1, 1'b0);
    chk_results("repulse", 1'b1, 0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Reset while stim=2 aborts the sweep.
    mode_a = 2; mode_b = 2;
    @(negedge clk) bus1.start = 1'b1;
    @(negedge clk) bus1.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_stim", 32'(bus1.stim), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_all", 32'(pack1()), 32'd0);
    rst_n = 1'b1;
    done_ever = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      done_ever = done_ever | bus1.done | bus1.busy;
    end
    chk("abort_idle", 32'(done_ever), 32'd0);

    // Longer settle: 4 minterms x 4 cycles.
    mode_a = 0; mode_b = 0;
    run_sweep(2, 16, 1'b0, 1'b0);
    chk("s3_pass", 32'(bus2.pass),      32'd1);
    chk("s3_cnt",  32'(bus2.err_count), 32'd0);
    chk("s3_stim", 32'(bus2.stim),      32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
